// File: rtl/dcache_flush_sequencer.sv
// Flush/invalidate walker for the write-back data cache.
// Walks an inclusive set range way by way, reads each directory entry and
// issues writebacks (dirty lines) and/or invalidates according to the mode.
module dcache_flush_sequencer #(
    parameter int NUM_SETS       = 256,
    parameter int NUM_WAYS       = 8,
    parameter bit INVAL_ON_FLUSH = 1'b0,
    parameter int CNT_W          = 16,
    parameter int SET_W          = $clog2(NUM_SETS),
    parameter int WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_mode_i,
    input  logic [SET_W-1:0] req_set_lo_i,
    input  logic [SET_W-1:0] req_set_hi_i,
    input  logic             abort_i,
    output logic             dir_rd_o,
    output logic [SET_W-1:0] dir_set_o,
    output logic [WAY_W-1:0] dir_way_o,
    input  logic             dir_valid_i,
    input  logic             dir_dirty_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic             inv_valid_o,
    input  logic             inv_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             aborted_o,
    output logic [CNT_W-1:0] wb_count_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_INV    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] MODE_FLUSH     = 2'b00;
    localparam logic [1:0] MODE_INV       = 2'b01;
    localparam logic [1:0] MODE_FLUSH_INV = 2'b10;
    localparam logic [1:0] MODE_RSVD      = 2'b11;

    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

    logic [2:0]       state;
    logic [1:0]       mode;
    logic [SET_W-1:0] set_hi;
    logic [SET_W-1:0] set_idx;
    logic [WAY_W-1:0] way_idx;
    logic [CNT_W-1:0] wb_count;
    logic             err_q;
    logic             abort_q;
    logic             abort_pend;

    logic             bad_req;
    logic             do_wb;
    logic             do_inv;
    logic [2:0]       adv_state;
    logic [SET_W-1:0] adv_set;
    logic [WAY_W-1:0] adv_way;

    // Request qualification, per-line action decode and next-line stepping.
    always_comb begin
        bad_req   = (req_mode_i == MODE_RSVD) || (req_set_lo_i > req_set_hi_i);
        do_wb     = ((mode == MODE_FLUSH) || (mode == MODE_FLUSH_INV)) && dir_valid_i && dir_dirty_i;
        do_inv    = ((mode == MODE_INV) || (mode == MODE_FLUSH_INV)) && dir_valid_i;
        adv_state = S_LOOKUP;
        adv_set   = set_idx;
        adv_way   = way_idx;
        if (way_idx != LAST_WAY) begin
            adv_way = way_idx + WAY_W'(1);
        end else if (set_idx == set_hi) begin
            // Terminating on equality with hi means hi = NUM_SETS-1 never wraps.
            adv_state = S_DONE;
        end else begin
            adv_set = set_idx + SET_W'(1);
            adv_way = '0;
        end
    end

    // Walker FSM with latched request, position counters and status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            mode       <= MODE_FLUSH;
            set_hi     <= '0;
            set_idx    <= '0;
            way_idx    <= '0;
            wb_count   <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        mode       <= (req_mode_i == MODE_FLUSH && INVAL_ON_FLUSH) ? MODE_FLUSH_INV : req_mode_i;
                        set_hi     <= req_set_hi_i;
                        set_idx    <= req_set_lo_i;
                        way_idx    <= '0;
                        wb_count   <= '0;
                        err_q      <= bad_req;
                        abort_q    <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= bad_req ? S_DONE : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (do_wb) begin
                        state <= S_WB;
                    end else if (do_inv) begin
                        state <= S_INV;
                    end else begin
                        state   <= adv_state;
                        set_idx <= adv_set;
                        way_idx <= adv_way;
                    end
                end
                S_WB: begin
                    // An abort seen while waiting is remembered so the
                    // outstanding request is never withdrawn before acceptance.
                    if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                    if (wb_ready_i) begin
                        if (wb_count != '1) begin
                            wb_count <= wb_count + CNT_W'(1);
                        end
                        if (abort_i || abort_pend) begin
                            abort_q <= 1'b1;
                            state   <= S_DONE;
                        end else if (mode == MODE_FLUSH_INV) begin
                            state <= S_INV;
                        end else begin
                            state   <= adv_state;
                            set_idx <= adv_set;
                            way_idx <= adv_way;
                        end
                    end
                end
                S_INV: begin
                    if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                    if (inv_ready_i) begin
                        if (abort_i || abort_pend) begin
                            abort_q <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state   <= adv_state;
                            set_idx <= adv_set;
                            way_idx <= adv_way;
                        end
                    end
                end
                S_DONE: begin
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the current state and latched status.
    always_comb begin
        req_ready_o = (state == S_IDLE);
        busy_o      = (state != S_IDLE);
        dir_rd_o    = (state == S_LOOKUP);
        wb_valid_o  = (state == S_WB);
        inv_valid_o = (state == S_INV);
        done_o      = (state == S_DONE);
        err_o       = (state == S_DONE) && err_q;
        aborted_o   = (state == S_DONE) && abort_q;
        dir_set_o   = set_idx;
        dir_way_o   = way_idx;
        wb_count_o  = wb_count;
    end

endmodule
